traffic_light_checker: RTL
==========================

// Module: traffic_light_checker
// PURPOSE
//  Observer at the receiving end of the red/yellow/green light interface: samples the
//  three light outputs of a traffic light controller every clock and checks them.
//  Checks: one-hot encoding, legal RED->GREEN->YELLOW->RED order, per-phase durations.
//  Sticky error flags and a violation counter are exposed for a host or the testbench.
//  Sits beside the controller in the user project; purely passive on the light lines.
// PARAMETERS
//  CNT_W          8    width of phase_cnt; counter saturates at 2**CNT_W-1
//  RED_MIN        4    minimum enabled cycles a timed RED phase must last
//  GREEN_MIN      4    minimum enabled cycles a timed GREEN phase must last
//  YELLOW_CYCLES  2    exact enabled cycles a timed YELLOW phase must last
//  MAX_PHASE      200  stall limit in cycles; used only when TLC_STALL_TIMEOUT_EN is defined
// PORTS
//  clk         in   1      system clock, rising edge
//  reset_n     in   1      asynchronous active-low reset
//  enable      in   1      1 = sample and check this cycle; 0 = freeze all state
//  red         in   1      observed red light
//  yellow      in   1      observed yellow light
//  green       in   1      observed green light
//  clear       in   1      synchronous clear of sticky error flags and err_count
//  phase       out  2      00 UNKNOWN, 01 RED, 10 GREEN, 11 YELLOW
//  phase_cnt   out  CNT_W  enabled cycles spent in current phase (1 on entry)
//  transition  out  1      1-cycle pulse on every accepted legal phase change
//  err_onehot  out  1      sticky: light code was not exactly one-hot
//  err_seq     out  1      sticky: illegal phase order
//  err_timing  out  1      sticky: phase duration out of spec
//  err_stall   out  1      sticky: phase exceeded MAX_PHASE (tied 0 without macro)
//  err_count   out  8      total violations, saturating at 255
// BEHAVIOUR
//  - Reset (reset_n=0, async): phase=UNKNOWN, phase_cnt=0, transition=0; all err_* = 0; err_count=0.
//  - All outputs are registered. They reflect the inputs sampled at the previous rising edge (latency 1).
//  - enable=0: no sampling, no checks, all registers hold, transition=0. clear is still honoured.
//  - Non-one-hot code (000, or 2+ lights set): set err_onehot, err_count+1; phase and phase_cnt hold.
//  - UNKNOWN + valid code: enter that phase, phase_cnt=1. The first phase is untimed (partial); no transition pulse.
//  - Same code as current phase: phase_cnt+1, saturating.
//  - Legal change (R->G, G->Y, Y->R): phase updates, phase_cnt=1, transition=1.
//  - On leaving a timed phase, err_timing is set if any of these holds:
//    RED with cnt<RED_MIN; GREEN with cnt<GREEN_MIN; YELLOW with cnt!=YELLOW_CYCLES.
//  - Illegal change (R->Y, G->R, Y->G): set err_seq. The phase still follows the observed code
//    (resync), phase_cnt=1, and the new phase is untimed.
//  - At most one err_count increment per cycle, even if several checks fail in that cycle.
//  - clear=1: err_* and err_count go to 0 next edge. If a violation occurs in the same cycle,
//    the violation wins: its flag is set and err_count=1.
//  - Reset asserted mid-phase returns to UNKNOWN immediately; no error is recorded.
// CONFIGURATION
//  TLC_STALL_TIMEOUT_EN defined: when phase_cnt reaches MAX_PHASE in a non-UNKNOWN phase,
//    err_stall is set and err_count+1, once per phase entry.
//  Not defined: err_stall is constant 0, and no stall logic is built.
// TESTING
//  1 reset_n=0 while lights toggle -> phase=00, err_count=0, all flags 0.
//  2 R x6, G x5, Y x2, R x4 -> 3 transition pulses, phase=01, phase_cnt=4, no errors.
//  3 R x6, G x5, Y x2, R x2, G -> err_timing=1, err_count=1, phase=10.
//  4 red=green=1 for 1 cycle in GREEN -> err_onehot=1, err_count+1, phase stays 10.
//  5 R x6 then Y -> err_seq=1, phase=11, phase_cnt=1; a following Y x2 then R gives no err_timing.
//  6 enable=0 for 10 cycles mid-GREEN -> phase_cnt frozen; clear with a violation in the same cycle
//    -> err_count=1. With macro, R held 200 cycles -> err_stall=1.

Source files
------------

// File: rtl/traffic_light_checker.sv
// Passive checker for a red/yellow/green light interface: one-hot, phase order and phase durations.
// Optional stall watchdog is built only when TLC_STALL_TIMEOUT_EN is defined.
module traffic_light_checker #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned RED_MIN       = 4,
  parameter int unsigned GREEN_MIN     = 4,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned MAX_PHASE     = 200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             transition,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_timing,
  output logic             err_stall,
  output logic [7:0]       err_count
);

  localparam int unsigned ERR_W = 8;

  localparam logic [1:0] PH_UNKNOWN = 2'b00;
  localparam logic [1:0] PH_RED     = 2'b01;
  localparam logic [1:0] PH_GREEN   = 2'b10;
  localparam logic [1:0] PH_YELLOW  = 2'b11;

  // The stall threshold has to be reachable by the saturating phase counter.
  if (MAX_PHASE == 0 || MAX_PHASE > (2 ** CNT_W) - 1) begin : g_bad_max_phase
    $error("MAX_PHASE must be within 1 .. 2**CNT_W-1");
  end

  logic             timed;
  logic [1:0]       phase_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timed_nxt;
  logic             trans_nxt;
  logic [1:0]       obs_phase;
  logic             obs_valid;
  logic             legal;
  logic             v_onehot;
  logic             v_seq;
  logic             v_timing;
  logic             v_any;
`ifdef TLC_STALL_TIMEOUT_EN
  logic             v_stall;
`endif

  // Decode the sampled light code into a phase.
  always_comb begin
    obs_valid = 1'b0;
    obs_phase = PH_UNKNOWN;
    case ({red, yellow, green})
      3'b100:  begin obs_valid = 1'b1; obs_phase = PH_RED;    end
      3'b001:  begin obs_valid = 1'b1; obs_phase = PH_GREEN;  end
      3'b010:  begin obs_valid = 1'b1; obs_phase = PH_YELLOW; end
      default: ;
    endcase
  end

  assign legal = (phase == PH_RED    && obs_phase == PH_GREEN)  ||
                 (phase == PH_GREEN  && obs_phase == PH_YELLOW) ||
                 (phase == PH_YELLOW && obs_phase == PH_RED);

  // Phase tracking and per-cycle violation detection.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = phase_cnt;
    timed_nxt = timed;
    trans_nxt = 1'b0;
    v_onehot  = 1'b0;
    v_seq     = 1'b0;
    v_timing  = 1'b0;
`ifdef TLC_STALL_TIMEOUT_EN
    v_stall   = 1'b0;
`endif
    if (enable) begin
      if (!obs_valid) begin
        v_onehot = 1'b1;
      end else if (phase == PH_UNKNOWN) begin
        phase_nxt = obs_phase;
        cnt_nxt   = CNT_W'(1);
        timed_nxt = 1'b0;
      end else if (obs_phase == phase) begin
        if (phase_cnt != '1) begin
          cnt_nxt = phase_cnt + CNT_W'(1);
`ifdef TLC_STALL_TIMEOUT_EN
          v_stall = (cnt_nxt == CNT_W'(MAX_PHASE));
`endif
        end
      end else begin
        if (timed) begin
          case (phase)
            PH_RED:    v_timing = (phase_cnt < CNT_W'(RED_MIN));
            PH_GREEN:  v_timing = (phase_cnt < CNT_W'(GREEN_MIN));
            PH_YELLOW: v_timing = (phase_cnt != CNT_W'(YELLOW_CYCLES));
            default:   v_timing = 1'b0;
          endcase
        end
        // An illegal change resyncs to the observed phase but leaves it untimed.
        phase_nxt = obs_phase;
        cnt_nxt   = CNT_W'(1);
        timed_nxt = legal;
        trans_nxt = legal;
        v_seq     = !legal;
      end
    end
  end

`ifdef TLC_STALL_TIMEOUT_EN
  assign v_any = v_onehot | v_seq | v_timing | v_stall;
`else
  assign v_any = v_onehot | v_seq | v_timing;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= PH_UNKNOWN;
      phase_cnt  <= '0;
      timed      <= 1'b0;
      transition <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      phase_cnt  <= cnt_nxt;
      timed      <= timed_nxt;
      transition <= trans_nxt;
    end
  end

  // Sticky flags and counter; a violation in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_timing <= 1'b0;
      err_count  <= '0;
    end else begin
      err_onehot <= v_onehot | (err_onehot & !clear);
      err_seq    <= v_seq    | (err_seq    & !clear);
      err_timing <= v_timing | (err_timing & !clear);
      if (v_any) begin
        if (clear)                err_count <= ERR_W'(1);
        else if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end else if (clear) begin
        err_count <= '0;
      end
    end
  end

`ifdef TLC_STALL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_stall <= 1'b0;
    else          err_stall <= v_stall | (err_stall & !clear);
  end
`else
  assign err_stall = 1'b0;
`endif

endmodule
